// File: rtl/spi_sclk_gen_if.sv
// rtl/spi_sclk_gen_if.sv - SPI serial-clock generator control/strobe interface
interface spi_sclk_gen_if #(
    parameter int DIV_W = 8,
    parameter int CNT_W = 6
) ();
    logic             start;
    logic [DIV_W-1:0] div;
    logic             cpol;
    logic             cpha;
    logic [CNT_W-1:0] num_bits;
    logic             sclk_out;
    logic             sample_stb;
    logic             shift_stb;
    logic             busy;
    logic             done;

    // Control FSM side: requests bursts and consumes strobes.
    modport master (
        output start, div, cpol, cpha, num_bits,
        input  sclk_out, sample_stb, shift_stb, busy, done
    );

    // Clock generator side.
    modport slave (
        input  start, div, cpol, cpha, num_bits,
        output sclk_out, sample_stb, shift_stb, busy, done
    );
endinterface

// File: rtl/spi_sclk_gen.sv
// rtl/spi_sclk_gen.sv - SPI SCLK generator with CPOL/CPHA, burst length and strobes; optional SPI_SCLK_GAP_EN
module spi_sclk_gen #(
    parameter int DIV_W = 8,
    parameter int CNT_W = 6
) (
    input  logic          clk_in,
    input  logic          rst_n,
    spi_sclk_gen_if.slave bus
);

`ifdef SPI_SCLK_GAP_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd3
    } state_t;
`endif

    state_t           state_q,   state_d;
    logic [DIV_W-1:0] hcnt_q,    hcnt_d;
    logic [CNT_W:0]   ecnt_q,    ecnt_d;
    logic [DIV_W-1:0] div_l_q,   div_l_d;
    logic             cpol_l_q,  cpol_l_d;
    logic             cpha_l_q,  cpha_l_d;
    logic [CNT_W-1:0] nbits_l_q, nbits_l_d;
    logic             sclk_q,    sclk_d;
    logic             sample_q,  sample_d;
    logic             shift_q,   shift_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;
    logic [CNT_W:0]   edge_num;

    // State, latched burst parameters and registered outputs.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            hcnt_q    <= '0;
            ecnt_q    <= '0;
            div_l_q   <= '0;
            cpol_l_q  <= 1'b0;
            cpha_l_q  <= 1'b0;
            nbits_l_q <= '0;
            sclk_q    <= 1'b0;
            sample_q  <= 1'b0;
            shift_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            hcnt_q    <= hcnt_d;
            ecnt_q    <= ecnt_d;
            div_l_q   <= div_l_d;
            cpol_l_q  <= cpol_l_d;
            cpha_l_q  <= cpha_l_d;
            nbits_l_q <= nbits_l_d;
            sclk_q    <= sclk_d;
            sample_q  <= sample_d;
            shift_q   <= shift_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next-state logic: half-period timing, edge counting and strobe classification.
    always_comb begin
        state_d   = state_q;
        hcnt_d    = hcnt_q;
        ecnt_d    = ecnt_q;
        div_l_d   = div_l_q;
        cpol_l_d  = cpol_l_q;
        cpha_l_d  = cpha_l_q;
        nbits_l_d = nbits_l_q;
        sclk_d    = sclk_q;
        sample_d  = 1'b0;
        shift_d   = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        edge_num  = ecnt_q + (CNT_W+1)'(1);

        case (state_q)
            S_IDLE: begin
                // Idle level tracks the live polarity so the line is correct before a burst.
                sclk_d = bus.cpol;
                hcnt_d = '0;
                ecnt_d = '0;
                if (bus.start) begin
                    div_l_d   = (bus.div == '0) ? DIV_W'(1) : bus.div;
                    cpol_l_d  = bus.cpol;
                    cpha_l_d  = bus.cpha;
                    nbits_l_d = bus.num_bits;
                    busy_d    = 1'b1;
                    state_d   = (bus.num_bits == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (hcnt_q == div_l_q - DIV_W'(1)) begin
                    hcnt_d = '0;
                    sclk_d = ~sclk_q;
                    ecnt_d = edge_num;
                    // Odd edges lead; the sample edge is leading for cpha=0, trailing for cpha=1.
                    if (edge_num[0] ^ cpha_l_q) begin
                        sample_d = 1'b1;
                    end else begin
                        shift_d = 1'b1;
                    end
                    if (edge_num == {nbits_l_q, 1'b0}) begin
`ifdef SPI_SCLK_GAP_EN
                        state_d = S_GAP;
`else
                        state_d = S_DONE;
`endif
                    end
                end else begin
                    hcnt_d = hcnt_q + DIV_W'(1);
                end
            end
`ifdef SPI_SCLK_GAP_EN
            S_GAP: begin
                // Hold idle level for one half-period so CS can be released with margin.
                sclk_d = cpol_l_q;
                if (hcnt_q == div_l_q - DIV_W'(1)) begin
                    hcnt_d  = '0;
                    state_d = S_DONE;
                end else begin
                    hcnt_d = hcnt_q + DIV_W'(1);
                end
            end
`endif
            S_DONE: begin
                sclk_d  = cpol_l_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign bus.sclk_out   = sclk_q;
    assign bus.sample_stb = sample_q;
    assign bus.shift_stb  = shift_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_spi_sclk_gen.sv
// tb/tb_spi_sclk_gen.sv - randomized self-checking bench for spi_sclk_gen
module tb_spi_sclk_gen;

`ifdef SPI_SCLK_GAP_EN
    localparam int GAP_ON = 1;
`else
    localparam int GAP_ON = 0;
`endif

    logic clk_in = 1'b0;
    logic rst_n  = 1'b0;
    int   errors = 0;
    int   checks = 0;

    spi_sclk_gen_if #(.DIV_W(8), .CNT_W(6)) bus ();

    spi_sclk_gen #(.DIV_W(8), .CNT_W(6)) dut (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    // Expected outputs in cycle c after acceptance (c=1 is the cycle after the accepting edge).
    // Packed as {sclk, sample, shift, busy, done}.
    function automatic logic [4:0] model(input int c, input int dv, input int n,
                                         input int cp, input int ch);
        int d;
        int r;
        int g;
        int k;
        logic e_sclk, e_smp, e_shf, e_busy, e_done;
        d = (dv == 0) ? 1 : dv;
        r = 2 * n * d;
        g = (n > 0 && GAP_ON == 1) ? d : 0;
        k = (c - 1) / d;
        if (k > 2 * n) k = 2 * n;
        e_sclk = 1'(cp ^ (k % 2));
        e_smp  = 1'b0;
        e_shf  = 1'b0;
        if (c > 1 && ((c - 1) % d) == 0 && (c - 1) / d <= 2 * n) begin
            if ((((c - 1) / d) % 2 == 1) == (ch == 0)) e_smp = 1'b1;
            else                                       e_shf = 1'b1;
        end
        e_busy = (c >= 1 && c <= r + g + 1);
        e_done = (c == r + g + 2);
        return {e_sclk, e_smp, e_shf, e_busy, e_done};
    endfunction

    function automatic logic [4:0] observed();
        return {bus.sclk_out, bus.sample_stb, bus.shift_stb, bus.busy, bus.done};
    endfunction

    task automatic test_reset();
        logic [4:0] obs;
        rst_n        = 1'b0;
        bus.start    = 1'b1;
        bus.div      = 8'd3;
        bus.cpol     = 1'b1;
        bus.cpha     = 1'b0;
        bus.num_bits = 6'd2;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_in); #1;
            obs = observed();
            checks++;
            if (obs !== 5'b00000) begin
                errors++;
                $display("FAIL reset_state cyc=%0d got=%b exp=00000", i, obs);
            end
        end
        bus.start = 1'b0;
        rst_n     = 1'b1;
        @(posedge clk_in); #1;
        checks++;
        if (bus.sclk_out !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_follow_cpol1 got sclk=%b busy=%b exp sclk=1 busy=0", bus.sclk_out, bus.busy);
        end
        bus.cpol = 1'b0;
        #1;
        checks++;
        if (bus.sclk_out !== 1'b1) begin
            errors++;
            $display("FAIL idle_lag got sclk=%b exp=1", bus.sclk_out);
        end
        @(posedge clk_in); #1;
        checks++;
        if (bus.sclk_out !== 1'b0) begin
            errors++;
            $display("FAIL idle_follow_cpol0 got sclk=%b exp=0", bus.sclk_out);
        end
    endtask

    // One burst from IDLE; with disturb, all inputs are scrambled while the burst is active.
    task automatic test_burst(input int dv, input int n, input int cp, input int ch, input bit disturb);
        int d;
        int last;
        logic [4:0] obs;
        logic [4:0] exp_v;
        d    = (dv == 0) ? 1 : dv;
        last = 2 * n * d + ((n > 0 && GAP_ON == 1) ? d : 0) + 1;
        bus.div      = 8'(dv);
        bus.num_bits = 6'(n);
        bus.cpol     = 1'(cp);
        bus.cpha     = 1'(ch);
        @(posedge clk_in); #1;
        bus.start = 1'b1;
        for (int c = 1; c <= last + 4; c++) begin
            @(posedge clk_in); #1;
            obs   = observed();
            exp_v = model(c, dv, n, cp, ch);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL burst div=%0d n=%0d cpol=%0d cpha=%0d dist=%0d c=%0d got=%b exp=%b",
                         dv, n, cp, ch, disturb, c, obs, exp_v);
            end
            if (disturb && c <= last) begin
                bus.start    = 1'($urandom);
                bus.div      = 8'($urandom);
                bus.cpol     = 1'($urandom);
                bus.cpha     = 1'($urandom);
                bus.num_bits = 6'($urandom);
            end else begin
                bus.start    = 1'b0;
                bus.div      = 8'(dv);
                bus.num_bits = 6'(n);
                bus.cpol     = 1'(cp);
                bus.cpha     = 1'(ch);
            end
        end
    endtask

    task automatic test_reset_midburst();
        logic [4:0] obs;
        logic [4:0] exp_v;
        int cp;
        int ch;
        cp = int'($urandom_range(0, 1));
        ch = int'($urandom_range(0, 1));
        bus.div      = 8'd3;
        bus.num_bits = 6'd4;
        bus.cpol     = 1'(cp);
        bus.cpha     = 1'(ch);
        @(posedge clk_in); #1;
        bus.start = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(posedge clk_in); #1;
            bus.start = 1'b0;
            obs   = observed();
            exp_v = model(c, 3, 4, cp, ch);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL pre_reset c=%0d got=%b exp=%b", c, obs, exp_v);
            end
        end
        rst_n = 1'b0;
        @(posedge clk_in); #1;
        rst_n = 1'b1;
        obs = observed();
        checks++;
        if (obs !== 5'b00000) begin
            errors++;
            $display("FAIL midburst_reset got=%b exp=00000", obs);
        end
        for (int c = 0; c < 30; c++) begin
            @(posedge clk_in); #1;
            obs = observed();
            checks++;
            if (obs !== {1'(cp), 4'b0000}) begin
                errors++;
                $display("FAIL post_reset_idle c=%0d got=%b exp=%b", c, obs, {1'(cp), 4'b0000});
            end
        end
    endtask

    // start held high throughout: ignored while busy and in DONE, accepted on the done cycle.
    task automatic test_back_to_back();
        int l1;
        int dones;
        logic [4:0] obs;
        logic [4:0] exp_v;
        l1 = 4 + 2 * GAP_ON + 2;
        dones = 0;
        bus.div      = 8'd2;
        bus.num_bits = 6'd1;
        bus.cpol     = 1'b0;
        bus.cpha     = 1'b0;
        @(posedge clk_in); #1;
        bus.start = 1'b1;
        for (int c = 1; c <= 2 * l1 + 3; c++) begin
            @(posedge clk_in); #1;
            obs   = observed();
            exp_v = (c <= l1) ? model(c, 2, 1, 0, 0) : model(c - l1, 2, 1, 0, 0);
            if (obs[0] === 1'b1) dones++;
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL back_to_back c=%0d got=%b exp=%b", c, obs, exp_v);
            end
            bus.start = (c < l1) ? 1'b1 : ((c == l1) ? 1'b1 : 1'b0);
        end
        checks++;
        if (dones !== 2) begin
            errors++;
            $display("FAIL back_to_back_done_count got=%0d exp=2", dones);
        end
    endtask

    task automatic test_random_bursts();
        for (int i = 0; i < 8; i++) begin
            test_burst(int'($urandom_range(0, 6)), int'($urandom_range(0, 5)),
                       int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.div      = '0;
        bus.cpol     = 1'b0;
        bus.cpha     = 1'b0;
        bus.num_bits = '0;
        test_reset();
        test_burst(5, 8, 0, 0, 1'b0);
        test_burst(0, 3, 1, 1, 1'b0);
        test_burst(7, 0, 1, 0, 1'b0);
        test_burst(4, 4, 0, 0, 1'b1);
        test_burst(3, 2, 0, 1, 1'b0);
        test_reset_midburst();
        test_burst(2, 3, 1, 0, 1'b0);
        test_back_to_back();
        test_random_bursts();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
